// File: rtl/pipelined_addsub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipelined_addsub : lane-pipelined add/subtract, valid/ready both ends |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NL = WIDTH / LANE_W;

  logic             adv;

  logic [NL-1:0]    valid_d, valid_q;
  logic [NL-1:0]    carry_d, carry_q;
  logic [WIDTH-1:0] a_d   [NL];
  logic [WIDTH-1:0] a_q   [NL];
  logic [WIDTH-1:0] b_d   [NL];
  logic [WIDTH-1:0] b_q   [NL];
  logic [WIDTH-1:0] sum_d [NL];
  logic [WIDTH-1:0] sum_q [NL];
  logic [TAG_W-1:0] tag_d [NL];
  logic [TAG_W-1:0] tag_q [NL];
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers.
  logic [NL-1:0]    src_valid, src_cin;
  logic [WIDTH-1:0] src_a   [NL];
  logic [WIDTH-1:0] src_b   [NL];
  logic [WIDTH-1:0] src_sum [NL];
  logic [TAG_W-1:0] src_tag [NL];
  logic [LANE_W:0]  lane_res [NL];

  assign adv = ~valid_q[NL-1] | out_ready;

  always_comb begin
    src_valid = '0;
    src_cin   = '0;
    src_a     = '{default: '0};
    src_b     = '{default: '0};
    src_sum   = '{default: '0};
    src_tag   = '{default: '0};
    lane_res  = '{default: '0};
    valid_d   = '0;
    carry_d   = '0;
    a_d       = '{default: '0};
    b_d       = '{default: '0};
    sum_d     = '{default: '0};
    tag_d     = '{default: '0};

    // Subtraction is A + ~B + ~borrow, so the inverted borrow rides the carry chain.
    src_valid[0] = in_valid;
    src_a[0]     = in_a;
    src_b[0]     = in_sub ? ~in_b : in_b;
    src_cin[0]   = in_sub ^ in_cin;
    src_sum[0]   = '0;
    src_tag[0]   = in_tag;

    for (int k = 1; k < NL; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_cin[k]   = carry_q[k-1];
      src_sum[k]   = sum_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end

    for (int k = 0; k < NL; k++) begin
      lane_res[k] = {1'b0, src_a[k][k*LANE_W +: LANE_W]}
                  + {1'b0, src_b[k][k*LANE_W +: LANE_W]}
                  + {{LANE_W{1'b0}}, src_cin[k]};
      valid_d[k]  = src_valid[k];
      a_d[k]      = src_a[k];
      b_d[k]      = src_b[k];
      tag_d[k]    = src_tag[k];
      carry_d[k]  = lane_res[k][LANE_W];
      sum_d[k]    = src_sum[k];
      sum_d[k][k*LANE_W +: LANE_W] = lane_res[k][LANE_W-1:0];
    end

    // Flags are resolved alongside the last lane so they stay aligned with out_sum.
    zero_d = (sum_d[NL-1] == '0);
    ovf_d  = (src_a[NL-1][WIDTH-1] == src_b[NL-1][WIDTH-1]) &
             (sum_d[NL-1][WIDTH-1] != src_a[NL-1][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < NL; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      tag_q   <= tag_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[NL-1];
  assign out_sum   = sum_q[NL-1];
  assign out_cout  = carry_q[NL-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q[NL-1];

endmodule
`default_nettype wire
